// File: rtl/axi_mem_responder_if.sv
// AXI4 read/write channel bundle between an accelerator initiator and axi_mem_responder.
// Clock and reset stay outside the bundle as plain ports.
interface axi_mem_responder_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int ID_W   = 16
);
  logic [ID_W-1:0]     arid_s;
  logic [ADDR_W-1:0]   araddr_s;
  logic [7:0]          arlen_s;
  logic [2:0]          arsize_s;
  logic                arvalid_s;
  logic                arready_s;

  logic [ID_W-1:0]     rid_s;
  logic [DATA_W-1:0]   rdata_s;
  logic [1:0]          rresp_s;
  logic                rlast_s;
  logic                rvalid_s;
  logic                rready_s;

  logic [ID_W-1:0]     awid_s;
  logic [ADDR_W-1:0]   awaddr_s;
  logic [7:0]          awlen_s;
  logic [2:0]          awsize_s;
  logic                awvalid_s;
  logic                awready_s;

  logic [DATA_W-1:0]   wdata_s;
  logic [DATA_W/8-1:0] wstrb_s;
  logic                wlast_s;
  logic                wvalid_s;
  logic                wready_s;

  logic [ID_W-1:0]     bid_s;
  logic [1:0]          bresp_s;
  logic                bvalid_s;
  logic                bready_s;

  modport slave (
    input  arid_s, araddr_s, arlen_s, arsize_s, arvalid_s,
    output arready_s,
    output rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
    input  rready_s,
    input  awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s,
    output awready_s,
    input  wdata_s, wstrb_s, wlast_s, wvalid_s,
    output wready_s,
    output bid_s, bresp_s, bvalid_s,
    input  bready_s
  );

  modport master (
    output arid_s, araddr_s, arlen_s, arsize_s, arvalid_s,
    input  arready_s,
    input  rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
    output rready_s,
    output awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s,
    input  awready_s,
    output wdata_s, wstrb_s, wlast_s, wvalid_s,
    input  wready_s,
    input  bid_s, bresp_s, bvalid_s,
    output bready_s
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 responder backed by a local word array: independent read and write engines,
// one INCR burst outstanding per direction, one beat per cycle, all outputs registered.
module axi_mem_responder #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 64,
  parameter int ID_W       = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input logic               clk,
  input logic               rst,
  axi_mem_responder_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [2:0] FULL_SIZE   = 3'(OFF);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic {R_IDLE, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef logic [DEPTH_LOG2-1:0] idx_t;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  r_state_e          r_state_q, r_state_d;
  idx_t              r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [7:0]        r_beat_q, r_beat_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  w_state_e          w_state_q, w_state_d;
  idx_t              w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [8:0]        w_beat_q, w_beat_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic              w_size_ok_q, w_size_ok_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s, w_keep_s;
  idx_t ar_idx_s, aw_idx_s;
  logic unused_addr_s;

  assign ar_hs_s  = bus.arvalid_s & arready_q;
  assign r_hs_s   = rvalid_q & bus.rready_s;
  assign aw_hs_s  = bus.awvalid_s & awready_q;
  assign w_hs_s   = bus.wvalid_s & wready_q;
  assign b_hs_s   = bvalid_q & bus.bready_s;
  // Beats past awlen are consumed but never reach the array.
  assign w_keep_s = w_hs_s & (w_beat_q <= {1'b0, w_len_q});
  assign ar_idx_s = bus.araddr_s[OFF +: DEPTH_LOG2];
  assign aw_idx_s = bus.awaddr_s[OFF +: DEPTH_LOG2];
  assign unused_addr_s = ^{bus.araddr_s[ADDR_W-1:OFF+DEPTH_LOG2], bus.araddr_s[OFF-1:0],
                           bus.awaddr_s[ADDR_W-1:OFF+DEPTH_LOG2], bus.awaddr_s[OFF-1:0]};

  // Read engine next state; rdata is loaded from the array before any same-edge write lands.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs_s) begin
          r_state_d = R_BURST;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = bus.arid_s;
          rdata_d   = mem_q[ar_idx_s];
          rresp_d   = (bus.arsize_s == FULL_SIZE) ? RESP_OKAY : RESP_SLVERR;
          rlast_d   = (bus.arlen_s == 8'd0);
          r_len_d   = bus.arlen_s;
          r_beat_d  = 8'd0;
          r_idx_d   = ar_idx_s + idx_t'(1);
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_BURST: begin
        if (r_hs_s && rlast_q) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
        end else if (r_hs_s) begin
          rdata_d  = mem_q[r_idx_q];
          r_idx_d  = r_idx_q + idx_t'(1);
          r_beat_d = r_beat_q + 8'd1;
          rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
        end else begin
          r_state_d = R_BURST;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // Write engine next state; the response flags any size or beat-count mismatch.
  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_beat_d    = w_beat_q;
    w_id_d      = w_id_q;
    w_size_ok_d = w_size_ok_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs_s) begin
          w_state_d   = W_DATA;
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          w_id_d      = bus.awid_s;
          w_idx_d     = aw_idx_s;
          w_len_d     = bus.awlen_s;
          w_beat_d    = 9'd0;
          w_size_ok_d = (bus.awsize_s == FULL_SIZE);
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s) begin
          w_idx_d  = w_idx_q + idx_t'(1);
          w_beat_d = (w_beat_q == 9'h1FF) ? w_beat_q : (w_beat_q + 9'd1);
          if (bus.wlast_s) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = (w_size_ok_q && (w_beat_q == {1'b0, w_len_q})) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers for both engines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q   <= R_IDLE;
      r_idx_q     <= '0;
      r_len_q     <= 8'd0;
      r_beat_q    <= 8'd0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= {ID_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      rresp_q     <= 2'd0;
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_len_q     <= 8'd0;
      w_beat_q    <= 9'd0;
      w_id_q      <= {ID_W{1'b0}};
      w_size_ok_q <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= {ID_W{1'b0}};
      bresp_q     <= 2'd0;
    end else begin
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      r_len_q     <= r_len_d;
      r_beat_q    <= r_beat_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      w_state_q   <= w_state_d;
      w_idx_q     <= w_idx_d;
      w_len_q     <= w_len_d;
      w_beat_q    <= w_beat_d;
      w_id_q      <= w_id_d;
      w_size_ok_q <= w_size_ok_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
    end
  end

  // Array storage is deliberately left out of reset so data survives an abandoned burst.
  always_ff @(posedge clk) begin
    if (w_keep_s) begin
      mem_q[w_idx_q] <= merge_bytes(mem_q[w_idx_q], bus.wdata_s, bus.wstrb_s);
    end
  end

  assign bus.arready_s = arready_q;
  assign bus.rvalid_s  = rvalid_q;
  assign bus.rlast_s   = rlast_q;
  assign bus.rid_s     = rid_q;
  assign bus.rdata_s   = rdata_q;
  assign bus.rresp_s   = rresp_q;
  assign bus.awready_s = awready_q;
  assign bus.wready_s  = wready_q;
  assign bus.bvalid_s  = bvalid_q;
  assign bus.bid_s     = bid_q;
  assign bus.bresp_s   = bresp_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a word-array reference model.
// Reads snapshot the model at each array load, which gives old-data-on-collision naturally.
module tb_axi_mem_responder;
  localparam int BUDGET = 2000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [511:0] mem_m [1024];
  logic [511:0] wq_data [$];
  logic [63:0]  wq_strb [$];

  axi_mem_responder_if bus ();

  axi_mem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_write(input int w, input logic [511:0] d, input logic [63:0] s);
    for (int b = 0; b < 64; b++) begin
      if (s[b]) mem_m[10'(w)][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  function automatic logic [511:0] rand_word();
    logic [511:0] d;
    for (int b = 0; b < 16; b++) d[b*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rand_addr(input int idx);
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[15:6] = 10'(idx);
    return a;
  endfunction

  task automatic axi_write(input int idx, input int len, input int nbeats, input logic [2:0] size,
                           input logic [15:0] id, input bit gaps, input bit slow_b);
    int beat;
    bit aw_done, b_done, aw_hs, w_hs, b_hs;
    logic [1:0] exp_resp;
    exp_resp = (size == 3'd6 && nbeats == len + 1) ? 2'd0 : 2'd2;
    beat = 0; aw_done = 1'b0; b_done = 1'b0;
    @(posedge clk); #1;
    bus.awid_s = id; bus.awaddr_s = rand_addr(idx); bus.awlen_s = 8'(len);
    bus.awsize_s = size; bus.awvalid_s = 1'b1;
    bus.wdata_s = wq_data[0]; bus.wstrb_s = wq_strb[0];
    bus.wlast_s = (nbeats == 1); bus.wvalid_s = 1'b1;
    for (int cyc = 0; cyc < BUDGET && !b_done; cyc++) begin
      aw_hs = bus.awvalid_s && bus.awready_s;
      w_hs  = bus.wvalid_s && bus.wready_s;
      b_hs  = bus.bvalid_s && bus.bready_s;
      if (!aw_done) chk("w_holdoff", 512'(bus.wready_s), 512'(1'b0));
      if (b_hs) begin
        chk("b_resp", 512'(bus.bresp_s), 512'(exp_resp));
        chk("b_id", 512'(bus.bid_s), 512'(id));
      end
      @(posedge clk); #1;
      if (aw_hs) begin
        aw_done = 1'b1;
        bus.awvalid_s = 1'b0;
      end
      if (w_hs) begin
        if (beat <= len) model_write(idx + beat, wq_data[beat], wq_strb[beat]);
        beat++;
        if (beat < nbeats) begin
          bus.wdata_s = wq_data[beat]; bus.wstrb_s = wq_strb[beat];
          bus.wlast_s = (beat == nbeats - 1);
          bus.wvalid_s = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
          bus.wvalid_s = 1'b0; bus.wlast_s = 1'b0;
          chk("b_latency", 512'(bus.bvalid_s), 512'(1'b1));
        end
      end else if (beat < nbeats) begin
        bus.wvalid_s = 1'b1;
      end
      if (b_hs) begin
        b_done = 1'b1;
        bus.bready_s = 1'b0;
        chk("aw_reopen", 512'(bus.awready_s), 512'(1'b1));
      end else if (bus.bvalid_s && !bus.bready_s) begin
        bus.bready_s = slow_b ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
    end
    if (!b_done) chk("w_timeout", 512'(1'b0), 512'(1'b1));
  endtask

  task automatic axi_read(input int idx, input int len, input logic [2:0] size,
                          input logic [15:0] id, input int rmode, output logic [511:0] beat0);
    int beat;
    bit ar_done, done, stall, ar_hs, r_hs;
    logic [511:0] exp_d, p_data;
    logic [19:0] p_ctl;
    logic [1:0] exp_resp;
    exp_resp = (size == 3'd6) ? 2'd0 : 2'd2;
    beat = 0; ar_done = 1'b0; done = 1'b0; stall = 1'b0;
    beat0 = '0; exp_d = '0; p_data = '0; p_ctl = '0;
    @(posedge clk); #2;
    bus.arid_s = id; bus.araddr_s = rand_addr(idx); bus.arlen_s = 8'(len);
    bus.arsize_s = size; bus.arvalid_s = 1'b1; bus.rready_s = (rmode == 0);
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      ar_hs = bus.arvalid_s && bus.arready_s;
      r_hs  = bus.rvalid_s && bus.rready_s;
      if (stall) begin
        chk("r_hold_data", bus.rdata_s, p_data);
        chk("r_hold_ctl", 512'({bus.rid_s, bus.rresp_s, bus.rlast_s, bus.rvalid_s}), 512'(p_ctl));
      end
      if (ar_done) chk("r_valid_held", 512'(bus.rvalid_s), 512'(1'b1));
      if (ar_hs) exp_d = mem_m[10'(idx)];
      if (r_hs) begin
        chk("r_data", bus.rdata_s, exp_d);
        chk("r_id", 512'(bus.rid_s), 512'(id));
        chk("r_resp", 512'(bus.rresp_s), 512'(exp_resp));
        chk("r_last", 512'(bus.rlast_s), 512'(beat == len));
        if (beat == 0) beat0 = bus.rdata_s;
        if (beat == len) done = 1'b1;
        else exp_d = mem_m[10'(idx + beat + 1)];
        beat++;
      end
      stall  = bus.rvalid_s && !bus.rready_s;
      p_data = bus.rdata_s;
      p_ctl  = {bus.rid_s, bus.rresp_s, bus.rlast_s, bus.rvalid_s};
      @(posedge clk); #2;
      if (ar_hs) begin
        ar_done = 1'b1;
        bus.arvalid_s = 1'b0;
        chk("r_latency", 512'(bus.rvalid_s), 512'(1'b1));
      end
      case (rmode)
        0:       bus.rready_s = 1'b1;
        1:       bus.rready_s = !bus.rready_s;
        default: bus.rready_s = 1'($urandom_range(0, 1));
      endcase
    end
    if (!done) begin
      chk("r_timeout", 512'(1'b0), 512'(1'b1));
    end else begin
      chk("r_end_valid", 512'(bus.rvalid_s), 512'(1'b0));
      chk("ar_reopen", 512'(bus.arready_s), 512'(1'b1));
    end
    bus.rready_s = 1'b0;
  endtask

  task automatic fill_write(input int n, input bit full, input bit rnd);
    wq_data.delete(); wq_strb.delete();
    for (int k = 0; k < n; k++) begin
      wq_data.push_back(rnd ? rand_word() : {64{8'(8'h11 * (k + 1))}});
      wq_strb.push_back(full ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] b0, old_w, d0;
    n_checks = 0; n_errors = 0;
    rst = 1'b1;
    bus.arid_s = '0; bus.araddr_s = '0; bus.arlen_s = '0; bus.arsize_s = '0; bus.arvalid_s = 1'b0;
    bus.rready_s = 1'b0;
    bus.awid_s = '0; bus.awaddr_s = '0; bus.awlen_s = '0; bus.awsize_s = '0; bus.awvalid_s = 1'b0;
    bus.wdata_s = '0; bus.wstrb_s = '0; bus.wlast_s = 1'b0; bus.wvalid_s = 1'b0;
    bus.bready_s = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    chk("rst_rdata", bus.rdata_s, 512'd0);
    chk("rst_ctl", 512'({bus.arready_s, bus.rvalid_s, bus.rlast_s, bus.rresp_s, bus.rid_s,
                         bus.awready_s, bus.wready_s, bus.bvalid_s, bus.bresp_s, bus.bid_s}), 512'd0);
    rst = 1'b0;
    #1;
    chk("rdy_before_edge", 512'({bus.arready_s, bus.awready_s}), 512'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", 512'({bus.arready_s, bus.awready_s}), 512'(2'b11));

    // Preload both ends of the array so every later read compares known data.
    fill_write(64, 1'b1, 1'b1);
    axi_write(0, 63, 64, 3'd6, 16'h0001, 1'b0, 1'b0);
    fill_write(8, 1'b1, 1'b1);
    axi_write(1016, 7, 8, 3'd6, 16'h0002, 1'b1, 1'b1);

    fill_write(4, 1'b1, 1'b0);
    axi_write(0, 3, 4, 3'd6, 16'h00A1, 1'b0, 1'b0);
    axi_read(0, 3, 3'd6, 16'h00B2, 0, b0);
    chk("wr_rd_beat0", b0, {64{8'h11}});

    fill_write(1, 1'b1, 1'b0);
    wq_data[0] = {512{1'b1}};
    axi_write(5, 0, 1, 3'd6, 16'h0003, 1'b0, 1'b0);
    wq_data[0] = '0; wq_strb[0] = 64'h0000_0000_0000_0001;
    axi_write(5, 0, 1, 3'd6, 16'h0004, 1'b0, 1'b0);
    axi_read(5, 0, 3'd6, 16'h0005, 0, b0);
    chk("partial_strobe", b0, {{63{8'hFF}}, 8'h00});

    axi_read(1023, 1, 3'd6, 16'h0006, 1, b0);
    chk("wrap_beat0", b0, mem_m[10'd1023]);

    axi_read(8, 2, 3'd5, 16'h0007, 2, b0);
    fill_write(4, 1'b1, 1'b1);
    axi_write(0, 3, 2, 3'd6, 16'h0008, 1'b0, 1'b0);
    axi_read(0, 3, 3'd6, 16'h0009, 0, b0);

    old_w = mem_m[10'd10];
    fill_write(1, 1'b1, 1'b1);
    fork
      axi_write(10, 0, 1, 3'd6, 16'h000A, 1'b0, 1'b0);
      axi_read(10, 0, 3'd6, 16'h000B, 0, b0);
    join
    chk("coll_old", b0, old_w);
    axi_read(10, 0, 3'd6, 16'h000C, 0, b0);
    chk("coll_new", b0, wq_data[0]);

    for (int it = 0; it < 30; it++) begin
      int widx, wlen, nb, ridx, rlen;
      logic [511:0] junk;
      widx = ($urandom_range(0, 3) == 0) ? 1016 + $urandom_range(0, 7) : $urandom_range(0, 47);
      ridx = ($urandom_range(0, 3) == 0) ? widx : $urandom_range(0, 47);
      wlen = $urandom_range(0, 15);
      rlen = $urandom_range(0, 15);
      case ($urandom_range(0, 5))
        0:       nb = (wlen > 0) ? wlen : 1;
        1:       nb = wlen + 2;
        default: nb = wlen + 1;
      endcase
      fill_write(nb, ($urandom_range(0, 1) == 1), 1'b1);
      fork
        begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          axi_write(widx, wlen, nb, ($urandom_range(0, 7) == 0) ? 3'd5 : 3'd6,
                    16'($urandom), 1'b1, 1'b1);
        end
        begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          axi_read(ridx, rlen, ($urandom_range(0, 7) == 0) ? 3'd4 : 3'd6,
                   16'($urandom), int'($urandom_range(0, 2)), junk);
        end
      join
    end

    // Abandon an 8-beat read and an 8-beat write during their third beat.
    d0 = rand_word();
    @(posedge clk); #1;
    bus.arid_s = 16'h0C01; bus.araddr_s = 64'd0; bus.arlen_s = 8'd7; bus.arsize_s = 3'd6;
    bus.arvalid_s = 1'b1; bus.rready_s = 1'b1;
    bus.awid_s = 16'h0C02; bus.awaddr_s = 64'd100 << 6; bus.awlen_s = 8'd7; bus.awsize_s = 3'd6;
    bus.awvalid_s = 1'b1;
    @(posedge clk); #1;
    bus.arvalid_s = 1'b0; bus.awvalid_s = 1'b0;
    bus.wdata_s = d0; bus.wstrb_s = '1; bus.wlast_s = 1'b0; bus.wvalid_s = 1'b1;
    @(posedge clk); #1;
    model_write(100, d0, '1);
    bus.wdata_s = ~d0;
    @(posedge clk); #1;
    model_write(101, ~d0, '1);
    bus.wdata_s = rand_word();
    chk("mid_beat2_valid", 512'({bus.rvalid_s, bus.wready_s}), 512'(2'b11));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdata", bus.rdata_s, 512'd0);
    chk("async_rst_ctl", 512'({bus.arready_s, bus.rvalid_s, bus.rlast_s, bus.rresp_s, bus.rid_s,
                               bus.awready_s, bus.wready_s, bus.bvalid_s, bus.bresp_s, bus.bid_s}), 512'd0);
    bus.wvalid_s = 1'b0; bus.rready_s = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rel_before_edge", 512'({bus.arready_s, bus.awready_s}), 512'd0);
    @(posedge clk); #1;
    chk("rel_after_edge", 512'({bus.arready_s, bus.awready_s}), 512'(2'b11));
    axi_read(100, 1, 3'd6, 16'h0C03, 0, b0);
    chk("retained_word", b0, d0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
